// File: rtl/rs232_fifo_if.sv
// Byte-stream bundle between the RS232 receiver, the show-ahead FIFO and the transmitter.
// The master drives writes and pops; the slave (FIFO) returns data, flags and level.
// overflow/underflow exist only when RS232_FIFO_STATUS_EN is defined.
interface rs232_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);

  // Write side (receiver facing)
  logic [WIDTH-1:0]    wr_data;
  logic                wren;
  logic                afull;
  logic                full;

  // Read side (transmitter facing)
  logic [WIDTH-1:0]    rd_data;
  logic                rden;
  logic                empty;
  logic [DEPTH_LOG2:0] level;

`ifdef RS232_FIFO_STATUS_EN
  logic                overflow;
  logic                underflow;

  modport master (
    output wr_data, wren, rden,
    input  afull, full, rd_data, empty, level, overflow, underflow
  );

  modport slave (
    input  wr_data, wren, rden,
    output afull, full, rd_data, empty, level, overflow, underflow
  );
`else
  modport master (
    output wr_data, wren, rden,
    input  afull, full, rd_data, empty, level
  );

  modport slave (
    input  wr_data, wren, rden,
    output afull, full, rd_data, empty, level
  );
`endif

endinterface

// File: rtl/rs232_fifo.sv
// Show-ahead byte FIFO between RS232 receiver and transmitter; optional sticky
// overflow/underflow flags enabled by RS232_FIFO_STATUS_EN.
// Latency: a write into an empty FIFO is on rd_data one edge later; pops have no bubbles.
// Backpressure: writes are dropped when full unless a pop happens in the same cycle;
// afull (level >= CAP-AFULL_MARGIN) is meant to drive ctsn_pin upstream.
module rs232_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int WIDTH        = 8,
  parameter int AFULL_MARGIN = 4   // legal range 1..CAP-1
) (
  input  logic        clock,
  input  logic        resetn,
  rs232_fifo_if.slave bus
);

  // Total capacity counts the output register plus the memory behind it.
  localparam int CAP       = 2 ** DEPTH_LOG2;
  localparam int MEM_DEPTH = CAP - 1;
  localparam int LW        = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [LW-1:0]         lvl_t;
  typedef logic [WIDTH-1:0]      dat_t;

  localparam lvl_t LVL_CAP   = lvl_t'(CAP);
  localparam lvl_t LVL_AFULL = lvl_t'(CAP - AFULL_MARGIN);
  // The memory holds CAP-1 slots, so the pointers wrap one short of 2**DEPTH_LOG2.
  localparam ptr_t PTR_LAST  = ptr_t'(MEM_DEPTH - 1);

  // State
  dat_t mem_q [MEM_DEPTH];
  dat_t mem_d [MEM_DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  dat_t out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  lvl_t level_q, level_d;
  logic full_q, full_d;
  logic afull_q, afull_d;

  // Decode
  logic rd_acc;
  logic wr_acc;
  lvl_t mem_cnt;
  logic mem_empty;
  logic out_free;
  logic load_mem;
  logic bypass;
  logic mem_wr;

  // Accept decisions and routing, all derived from registered flags only.
  always_comb begin
    rd_acc    = bus.rden & out_valid_q;
    wr_acc    = bus.wren & (~full_q | rd_acc);
    // Entries in memory = total level minus the one parked in the output register.
    mem_cnt   = level_q - lvl_t'(out_valid_q);
    mem_empty = (mem_cnt == '0);
    // The output register can take a new entry if it is empty or being popped now.
    out_free  = ~out_valid_q | rd_acc;
    load_mem  = out_free & ~mem_empty;
    // With nothing queued in memory, incoming data skips it and falls straight through.
    bypass    = out_free & mem_empty & wr_acc;
    mem_wr    = wr_acc & ~bypass;
  end

  // Next state for output register, pointers, level and flags.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (load_mem) begin
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
      rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ptr_t'(1);
    end else if (bypass) begin
      out_data_d  = bus.wr_data;
      out_valid_d = 1'b1;
    end else if (rd_acc) begin
      // Last entry popped; rd_data keeps its stale value but empty rises.
      out_valid_d = 1'b0;
    end

    if (mem_wr) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ptr_t'(1);
    end

    level_d = level_q + lvl_t'(wr_acc) - lvl_t'(rd_acc);
    full_d  = (level_d == LVL_CAP);
    afull_d = (level_d >= LVL_AFULL);
  end

  // Memory write data; when full with a simultaneous pop the slot being read is
  // also the slot being written, which is safe because the read above sees the old value.
  always_comb begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (mem_wr) begin
      mem_d[wr_ptr_q] = bus.wr_data;
    end
  end

  // Storage array: contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control and output registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
    end
  end

  assign bus.rd_data = out_data_q;
  assign bus.empty   = ~out_valid_q;
  assign bus.level   = level_q;
  assign bus.full    = full_q;
  assign bus.afull   = afull_q;

`ifdef RS232_FIFO_STATUS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: a dropped write or a pop with nothing to pop.
  always_comb begin
    overflow_d  = overflow_q  | (bus.wren & full_q & ~bus.rden);
    underflow_d = underflow_q | (bus.rden & ~out_valid_q);
  end

  // Sticky flag registers, cleared only by reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_rs232_fifo.sv
// Bench for rs232_fifo: vector table, directed corner sequences, and randomized
// traffic checked against a queue-based model of the FIFO.
module tb_rs232_fifo;

  localparam int CAP   = 16;
  localparam int AFULL = 12;

  logic clock;
  logic resetn;

  rs232_fifo_if #(.WIDTH(8), .DEPTH_LOG2(4)) bus ();

  rs232_fifo #(.DEPTH_LOG2(4), .WIDTH(8), .AFULL_MARGIN(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of bytes plus sticky flags.
  logic [7:0] mq [$];
  bit m_ovf;
  bit m_unf;

  typedef struct {
    bit         wren;
    logic [7:0] wd;
    bit         rden;
    int         exp_level;
    bit         exp_empty;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model applies the pop before the push.
  task automatic drive_cycle(input bit w, input logic [7:0] d, input bit r);
    bit ra;
    bit wa;
    bus.wren    = w;
    bus.wr_data = d;
    bus.rden    = r;
    ra = r && (mq.size() > 0);
    wa = w && ((mq.size() < CAP) || ra);
    if (w && (mq.size() == CAP) && !r) m_ovf = 1'b1;
    if (r && (mq.size() == 0)) m_unf = 1'b1;
    @(posedge clock);
    #1;
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back(d);
    bus.wren = 1'b0;
    bus.rden = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"}, 32'(bus.level), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(bus.full),  32'(mq.size() == CAP));
    chk({tag, ".afull"}, 32'(bus.afull), 32'(mq.size() >= AFULL));
    if (mq.size() > 0) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(mq[0]));
`ifdef RS232_FIFO_STATUS_EN
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".empty"},   32'(bus.empty),   32'd1);
    chk({tag, ".level"},   32'(bus.level),   32'd0);
    chk({tag, ".full"},    32'(bus.full),    32'd0);
    chk({tag, ".afull"},   32'(bus.afull),   32'd0);
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'd0);
`ifdef RS232_FIFO_STATUS_EN
    chk({tag, ".overflow"},  32'(bus.overflow),  32'd0);
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'd0);
`endif
  endtask

  // Asynchronous reset pulse taken between clock edges; checks take effect before any edge.
  task automatic pulse_reset(input string tag);
    resetn = 1'b0;
    #2;
    check_reset_state(tag);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    int pw;
    int pr;
    bus.wren    = 1'b0;
    bus.rden    = 1'b0;
    bus.wr_data = '0;
    resetn      = 1'b0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;

    // Expected results worked out by hand from an empty FIFO.
    vt[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 8'hA5};  // fall-through write
    vt[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00};  // pop last entry
    vt[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00};  // pop while empty: ignored
    vt[3] = '{1'b1, 8'h3C, 1'b1, 1, 1'b0, 8'h3C};  // write+pop while empty
    vt[4] = '{1'b1, 8'h11, 1'b0, 2, 1'b0, 8'h3C};
    vt[5] = '{1'b1, 8'h22, 1'b1, 2, 1'b0, 8'h11};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h22};
    vt[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00};

    #12;
    check_reset_state("reset_init");
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check_reset_state("reset_idle");

    // Vector table
    for (int i = 0; i < 8; i++) begin
      drive_cycle(vt[i].wren, vt[i].wd, vt[i].rden);
      chk($sformatf("vec%0d.level", i), 32'(bus.level), 32'(vt[i].exp_level));
      chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vt[i].exp_empty));
      if (!vt[i].exp_empty)
        chk($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data), 32'(vt[i].exp_data));
    end

    // Reset in the middle of a stream
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'h40 + i), 1'b0);
    chk("midstream.level", 32'(bus.level), 32'd5);
    pulse_reset("reset_mid");
    check_model("after_reset_mid");

    // Fill to capacity, drop the extra write, drain in order
    for (int i = 0; i < CAP; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0);
      chk($sformatf("fill%0d.afull", i), 32'(bus.afull), 32'((i + 1) >= 12));
      chk($sformatf("fill%0d.full", i),  32'(bus.full),  32'((i + 1) == 16));
    end
    drive_cycle(1'b1, 8'hFF, 1'b0);
    chk("drop.level", 32'(bus.level), 32'd16);
    chk("drop.head",  32'(bus.rd_data), 32'h00);
    for (int i = 0; i < CAP; i++) begin
      chk($sformatf("drain%0d.data", i), 32'(bus.rd_data), 32'(i));
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
    chk("drain.empty", 32'(bus.empty), 32'd1);
    chk("drain.level", 32'(bus.level), 32'd0);

    // Simultaneous write and pop while full
    for (int i = 0; i < CAP; i++) drive_cycle(1'b1, 8'(i), 1'b0);
    drive_cycle(1'b1, 8'h10, 1'b1);
    chk("simfull.level", 32'(bus.level), 32'd16);
    chk("simfull.data",  32'(bus.rd_data), 32'h01);
    chk("simfull.full",  32'(bus.full), 32'd1);
    for (int i = 1; i <= CAP; i++) begin
      chk($sformatf("simdrain%0d.data", i), 32'(bus.rd_data), 32'(i));
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
    chk("simdrain.empty", 32'(bus.empty), 32'd1);

    // Streaming at level 3 across pointer wrap
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(i), 1'b0);
    for (int n = 0; n < 40; n++) begin
      chk($sformatf("wrap%0d.data", n), 32'(bus.rd_data), 32'(8'(n)));
      drive_cycle(1'b1, 8'(n + 3), 1'b1);
      chk($sformatf("wrap%0d.level", n), 32'(bus.level), 32'd3);
    end
    check_model("wrap_end");

    // Randomized traffic in phases biased toward full, empty and balanced
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin pw = 85; pr = 30; end
        1: begin pw = 25; pr = 85; end
        2: begin pw = 60; pr = 60; end
        default: begin pw = 95; pr = 10; end
      endcase
      for (int c = 0; c < 150; c++) begin
        drive_cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
        check_model($sformatf("rand%0d_%0d", ph, c));
      end
    end

`ifdef RS232_FIFO_STATUS_EN
    // Sticky status flags
    pulse_reset("reset_sticky");
    drive_cycle(1'b0, 8'h00, 1'b1);
    chk("sticky.underflow", 32'(bus.underflow), 32'd1);
    chk("sticky.ovf_clear", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < CAP; i++) drive_cycle(1'b1, 8'(i), 1'b0);
    chk("sticky.ovf_not_yet", 32'(bus.overflow), 32'd0);
    drive_cycle(1'b1, 8'hEE, 1'b0);
    chk("sticky.overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    chk("sticky.ovf_hold", 32'(bus.overflow), 32'd1);
    chk("sticky.unf_hold", 32'(bus.underflow), 32'd1);
    check_model("sticky");
    pulse_reset("reset_flags");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
